// File: rtl/pipeline_pkg.sv
// Shared types for the EX-stage hazard and forwarding controller.
// Forward selector codes, controller state and scoreboard entry.
package pipeline_pkg;

  localparam int RB_W = 4;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MEM_WAIT   = 2'b10
  } hz_state_t;

  typedef struct packed {
    logic [RB_W-1:0] rd;
    logic            regWrite;
    logic            memRead;
    logic            memAccess;
  } stage_info_t;

  // Nearest producer wins: EX result beats MEM result.
  function automatic fwd_sel_t fwd_pick(
    input logic            uses,
    input logic [RB_W-1:0] rs,
    input stage_info_t     ex,
    input stage_info_t     mem
  );
    if (uses && ex.regWrite && ex.rd == rs)
      return FWD_MEM;
    if (uses && mem.regWrite && mem.rd == rs)
      return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/stage_tracker.sv
// EX/MEM/WB destination scoreboard.
// Shifts each cycle unless held; EX takes a bubble on request.
module stage_tracker
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  input  logic        hold,
  input  logic        bubble,
  input  stage_info_t id,
  output stage_info_t ex,
  output stage_info_t mem,
  output stage_info_t wb
);

  // Advance the scoreboard one stage per unfrozen cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else if (!hold) begin
      wb  <= mem;
      mem <= ex;
      ex  <= bubble ? '0 : id;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Execute-stage hazard detection and forwarding control.
// Stall/flush are combinational; selectors and state are registered.
module hazard_forward_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_BITS = RB_W
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic [REG_BITS-1:0] idRs1,
  input  logic [REG_BITS-1:0] idRs2,
  input  logic                idUsesRs1,
  input  logic                idUsesRs2,
  input  logic [REG_BITS-1:0] idRd,
  input  logic                idRegWrite,
  input  logic                idMemRead,
  input  logic                idMemAccess,
  input  logic                branchTaken,
  input  logic                memReady,
  output logic [1:0]          data1ForwardSelector,
  output logic [1:0]          data2ForwardSelector,
  output logic                stallF,
  output logic                stallD,
  output logic                stallE,
  output logic                stallM,
  output logic                flushD,
  output logic                flushE
);

  stage_info_t id_info;
  stage_info_t ex;
  stage_info_t mem;
  stage_info_t wb;
  fwd_sel_t    sel1_n;
  fwd_sel_t    sel2_n;
  fwd_sel_t    sel1_q;
  fwd_sel_t    sel2_q;
  hz_state_t   state;
  logic        memWait;
  logic        loadUse;

  assign id_info = '{
    rd:        idRd,
    regWrite:  idRegWrite,
    memRead:   idMemRead,
    memAccess: idMemAccess
  };

  stage_tracker u_track (
    .clk    (clk),
    .resetN (resetN),
    .hold   (memWait),
    .bubble (flushE),
    .id     (id_info),
    .ex     (ex),
    .mem    (mem),
    .wb     (wb)
  );

  // Hazard detection and prioritised stall/flush decode.
  always_comb begin
    memWait = mem.memAccess && !memReady;
    sel1_n  = fwd_pick(idUsesRs1, idRs1, ex, mem);
    sel2_n  = fwd_pick(idUsesRs2, idRs2, ex, mem);
    loadUse = ex.memRead &&
              (sel1_n == FWD_MEM || sel2_n == FWD_MEM);
    stallF  = 1'b0;
    stallD  = 1'b0;
    stallE  = 1'b0;
    stallM  = 1'b0;
    flushD  = 1'b0;
    flushE  = 1'b0;
    priority case (1'b1)
      memWait: begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
      end
      branchTaken: begin
        flushD = 1'b1;
        flushE = 1'b1;
      end
      loadUse: begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
      default: ;
    endcase
  end

  // Selector registers and observable controller state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sel1_q <= FWD_REG;
      sel2_q <= FWD_REG;
      state  <= RUN;
    end else if (memWait) begin
      state  <= MEM_WAIT;
    end else if (flushE) begin
      sel1_q <= FWD_REG;
      sel2_q <= FWD_REG;
      state  <= branchTaken ? RUN : LOAD_STALL;
    end else begin
      sel1_q <= sel1_n;
      sel2_q <= sel2_n;
      state  <= RUN;
    end
  end

  assign data1ForwardSelector = sel1_q;
  assign data2ForwardSelector = sel2_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: directed scenarios plus
// randomized traffic against a behavioural pipeline model.
module tb_hazard_forward_ctrl;
  import pipeline_pkg::*;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [3:0] idRs1, idRs2, idRd;
  logic       idUsesRs1, idUsesRs2;
  logic       idRegWrite, idMemRead, idMemAccess;
  logic       branchTaken, memReady;
  logic [1:0] data1ForwardSelector, data2ForwardSelector;
  logic       stallF, stallD, stallE, stallM, flushD, flushE;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.REG_BITS(4)) dut (
    .clk                  (clk),
    .resetN               (resetN),
    .idRs1                (idRs1),
    .idRs2                (idRs2),
    .idUsesRs1            (idUsesRs1),
    .idUsesRs2            (idUsesRs2),
    .idRd                 (idRd),
    .idRegWrite           (idRegWrite),
    .idMemRead            (idMemRead),
    .idMemAccess          (idMemAccess),
    .branchTaken          (branchTaken),
    .memReady             (memReady),
    .data1ForwardSelector (data1ForwardSelector),
    .data2ForwardSelector (data2ForwardSelector),
    .stallF               (stallF),
    .stallD               (stallD),
    .stallE               (stallE),
    .stallM               (stallM),
    .flushD               (flushD),
    .flushE               (flushE)
  );

  // Model: instruction occupying each later stage.
  typedef struct {
    int rd;
    bit wr;
    bit ld;
    bit ma;
  } instr_t;

  instr_t m_ex, m_mem;
  int     m_s1, m_s2;
  bit     e_sF, e_sD, e_sE, e_sM, e_fD, e_fE, e_wait;
  int     e_n1, e_n2;

  function automatic void model_reset();
    m_ex  = '{0, 0, 0, 0};
    m_mem = '{0, 0, 0, 0};
    m_s1  = 0;
    m_s2  = 0;
  endfunction

  // Where operand value comes from: 2 = EX result, 1 = MEM result.
  function automatic int source(bit u, int rs);
    if (!u) return 0;
    if (m_ex.wr && m_ex.rd == rs) return 2;
    if (m_mem.wr && m_mem.rd == rs) return 1;
    return 0;
  endfunction

  function automatic void model_eval();
    bit needs_load;
    e_n1 = source(idUsesRs1, int'(idRs1));
    e_n2 = source(idUsesRs2, int'(idRs2));
    e_wait = m_mem.ma && !memReady;
    needs_load = m_ex.ld && m_ex.wr &&
      ((idUsesRs1 && m_ex.rd == int'(idRs1)) ||
       (idUsesRs2 && m_ex.rd == int'(idRs2)));
    {e_sF, e_sD, e_sE, e_sM, e_fD, e_fE} = '0;
    if (e_wait) begin
      {e_sF, e_sD, e_sE, e_sM} = 4'hF;
    end else if (branchTaken) begin
      e_fD = 1; e_fE = 1;
    end else if (needs_load) begin
      e_sF = 1; e_sD = 1; e_fE = 1;
    end
  endfunction

  function automatic void model_step();
    if (e_wait) return;
    m_mem = m_ex;
    if (e_fE) begin
      m_ex = '{0, 0, 0, 0};
      m_s1 = 0;
      m_s2 = 0;
    end else begin
      m_ex = '{int'(idRd), idRegWrite, idMemRead, idMemAccess};
      m_s1 = e_n1;
      m_s2 = e_n2;
    end
  endfunction

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic drive(input int rs1, input int rs2,
                       input bit u1, input bit u2,
                       input int rd, input bit rw, input bit mr,
                       input bit ma, input bit br, input bit rdy);
    idRs1 = 4'(rs1);
    idRs2 = 4'(rs2);
    idUsesRs1 = u1;
    idUsesRs2 = u2;
    idRd = 4'(rd);
    idRegWrite = rw;
    idMemRead = mr;
    idMemAccess = ma;
    branchTaken = br;
    memReady = rdy;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Compare every output with the model, then clock once.
  task automatic cyc();
    #1;
    model_eval();
    chk("stallF", stallF, e_sF);
    chk("stallD", stallD, e_sD);
    chk("stallE", stallE, e_sE);
    chk("stallM", stallM, e_sM);
    chk("flushD", flushD, e_fD);
    chk("flushE", flushE, e_fE);
    chk("sel1", data1ForwardSelector, m_s1);
    chk("sel2", data2ForwardSelector, m_s2);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    nop();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_stallF", stallF, 0);
    chk("rst_stallM", stallM, 0);
    chk("rst_flushE", flushE, 0);
    chk("rst_sel1", data1ForwardSelector, 0);
    chk("rst_state", dut.state, RUN);
    @(negedge clk);
    resetN = 1'b1;

    // ADD r3 then SUB rs1=r3: EX forward.
    drive(0, 0, 0, 0, 3, 1, 0, 0, 0, 1); cyc();
    drive(3, 1, 1, 1, 4, 1, 0, 0, 0, 1);
    #1 chk("t1_stallF", stallF, 0);
    cyc();
    chk("t1_sel1", data1ForwardSelector, 2'b10);
    chk("t1_sel2", data2ForwardSelector, 2'b00);

    // ADD r3, NOP, ORR rs2=r3: MEM forward.
    drive(0, 0, 0, 0, 3, 1, 0, 0, 0, 1); cyc();
    nop(); cyc();
    drive(0, 3, 0, 1, 9, 1, 0, 0, 0, 1); cyc();
    chk("t2_sel2", data2ForwardSelector, 2'b01);
    // Same rd in EX and MEM: nearest wins.
    drive(0, 0, 0, 0, 4, 1, 0, 0, 0, 1); cyc();
    drive(0, 0, 0, 0, 4, 1, 0, 0, 0, 1); cyc();
    drive(4, 0, 1, 0, 5, 1, 0, 0, 0, 1); cyc();
    chk("t2_near", data1ForwardSelector, 2'b10);

    // LDR r5 then ADD rs1=r5: one bubble.
    drive(0, 0, 0, 0, 5, 1, 1, 1, 0, 1); cyc();
    drive(5, 0, 1, 0, 6, 1, 0, 0, 0, 1);
    #1;
    chk("t3_stallF", stallF, 1);
    chk("t3_stallD", stallD, 1);
    chk("t3_flushE", flushE, 1);
    cyc();
    chk("t3_state", dut.state, LOAD_STALL);
    #1 chk("t3_release", stallF, 0);
    cyc();
    chk("t3_sel1", data1ForwardSelector, 2'b01);
    chk("t3_state2", dut.state, RUN);

    // Store waits 3 cycles in MEM; branch ignored while frozen.
    drive(0, 0, 0, 0, 7, 1, 0, 0, 0, 1); cyc();
    drive(7, 0, 1, 0, 0, 0, 0, 1, 0, 1); cyc();
    drive(0, 7, 0, 1, 8, 1, 0, 0, 0, 1); cyc();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, i == 1, 0);
      #1;
      chk("t4_stallE", stallE, 1);
      chk("t4_stallM", stallM, 1);
      chk("t4_flushD", flushD, 0);
      chk("t4_sel2", data2ForwardSelector, 2'b01);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    #1;
    chk("t4_relE", stallE, 0);
    chk("t4_brD", flushD, 1);
    cyc();

    // Branch beats a pending load-use.
    drive(0, 0, 0, 0, 5, 1, 1, 1, 0, 1); cyc();
    drive(5, 0, 1, 0, 6, 1, 0, 0, 1, 1);
    #1;
    chk("t5_flushD", flushD, 1);
    chk("t5_flushE", flushE, 1);
    chk("t5_stallF", stallF, 0);
    cyc();
    chk("t5_sel1", data1ForwardSelector, 2'b00);

    // Reset during a memory wait.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1); cyc();
    drive(0, 0, 0, 0, 2, 1, 0, 0, 0, 1); cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("t6_wait", stallM, 1);
    #2 resetN = 1'b0;
    model_reset();
    #1;
    chk("t6_stallF", stallF, 0);
    chk("t6_stallM", stallM, 0);
    chk("t6_sel1", data1ForwardSelector, 0);
    @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    drive(2, 2, 1, 1, 3, 1, 0, 0, 0, 1); cyc();
    chk("t6_nofwd", data1ForwardSelector, 2'b00);

    // Randomized traffic with a small register set.
    for (int n = 0; n < 3000; n++) begin
      bit rw, mr, ma;
      rw = 1'($urandom_range(0, 1));
      mr = rw && ($urandom_range(0, 2) == 0);
      ma = mr || ($urandom_range(0, 5) == 0);
      drive($urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), rw, mr, ma,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) != 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
